// File: rtl/poly_stream_tx_if.sv
// -----------------------------------------------------------------------------
// poly_stream_tx_if
// Handshake/data bundle between a polynomial source and poly_stream_tx.
//
// Signals:
//   LOAD            source -> tx  request to capture poly_in and start a frame
//   poly_in [Nb]    source -> tx  packed polynomial, coeff i at [i*b+b-1 : i*b]
//   HOLD            source -> tx  stall request while streaming
//   WRITE           tx -> source  one-cycle frame-start strobe
//   data_out_ready  tx -> source  data_out valid this cycle
//   data_out [b]    tx -> source  current coefficient (or checksum beat)
//   busy            tx -> source  frame in progress
//   done            tx -> source  one-cycle end-of-frame pulse
//
// Modports: master = polynomial source side, slave = poly_stream_tx side.
// -----------------------------------------------------------------------------
interface poly_stream_tx_if #(
  parameter int b  = 5,
  parameter int Nb = 40
);
  logic          LOAD;
  logic [Nb-1:0] poly_in;
  logic          HOLD;
  logic          WRITE;
  logic          data_out_ready;
  logic [b-1:0]  data_out;
  logic          busy;
  logic          done;

  modport master (
    output LOAD, poly_in, HOLD,
    input  WRITE, data_out_ready, data_out, busy, done
  );

  modport slave (
    input  LOAD, poly_in, HOLD,
    output WRITE, data_out_ready, data_out, busy, done
  );
endinterface

// File: rtl/poly_stream_tx.sv
// -----------------------------------------------------------------------------
// poly_stream_tx
// Captures a packed polynomial on LOAD and streams its N coefficients, LSB
// slice first, one per cycle, stallable with HOLD. A frame is:
//   START (WRITE strobe) -> N data beats -> [checksum beat] -> DONE pulse.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    poly_stream_tx_if.slave (LOAD, poly_in, HOLD in; WRITE,
//          data_out_ready, data_out, busy, done out; all outputs registered)
//
// Build option:
//   POLY_CHECKSUM_EN  when defined, a CHK state appends one beat carrying the
//                     sum of all N coefficients modulo 2^b.
//
// The state register names the phase of the *current* cycle; every output is
// registered from the next state so it lines up with that phase: LOAD seen at
// edge k gives WRITE in cycle k+1 and coeff[0] in cycle k+2 (HOLD low).
// -----------------------------------------------------------------------------
module poly_stream_tx #(
  parameter int p    = 17,
  parameter int N    = 8,
  parameter int logN = 3,
  parameter int b    = 5,
  parameter int Nb   = N * b
) (
  input logic             clk,
  input logic             reset,
  poly_stream_tx_if.slave bus
);

`ifdef POLY_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SEND  = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SEND  = 3'd2,
    S_DONE  = 3'd4
  } state_t;
`endif

  localparam logic [logN-1:0] LAST_IDX = logN'(N - 1);

  // p only exists to keep the parameter set aligned with the polynomial store;
  // an empty g_bad_params block in the hierarchy flags an inconsistent set.
  localparam bit PARAMS_OK = (N == (1 << logN)) && (Nb == N * b) && (p > 1);
  if (!PARAMS_OK) begin : g_bad_params
  end

  // Extract coefficient idx from a packed polynomial.
  function automatic logic [b-1:0] coeff_at(input logic [Nb-1:0] poly,
                                            input logic [logN-1:0] idx);
    logic [Nb-1:0] shifted;
    shifted = poly >> (idx * b);
    return shifted[b-1:0];
  endfunction

  state_t          state_q, state_d;
  logic [Nb-1:0]   shadow_q, shadow_d;
  logic [logN-1:0] idx_q, idx_d;
  // Set once the last beat of the current state has been issued; the index
  // itself stops at N-1 instead of wrapping.
  logic            sent_q, sent_d;
  logic            write_q, write_d;
  logic            ready_q, ready_d;
  logic [b-1:0]    dout_q, dout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [b-1:0]    coeff_s;
`ifdef POLY_CHECKSUM_EN
  logic [b-1:0]    sum_q, sum_d;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    sent_d   = sent_q;
    dout_d   = dout_q;
    ready_d  = 1'b0;
`ifdef POLY_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    coeff_s  = coeff_at(shadow_q, idx_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.LOAD) begin
          state_d  = S_START;
          shadow_d = bus.poly_in;
          idx_d    = '0;
          sent_d   = 1'b0;
`ifdef POLY_CHECKSUM_EN
          sum_d    = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      // The edge leaving START already issues coeff[0] when HOLD is low.
      S_START, S_SEND: begin
        if (sent_q) begin
          sent_d = 1'b0;
`ifdef POLY_CHECKSUM_EN
          state_d = S_CHK;
          if (!bus.HOLD) begin
            dout_d  = sum_q;
            ready_d = 1'b1;
            sent_d  = 1'b1;
          end else begin
            ready_d = 1'b0;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_SEND;
          if (!bus.HOLD) begin
            dout_d  = coeff_s;
            ready_d = 1'b1;
`ifdef POLY_CHECKSUM_EN
            sum_d   = sum_q + coeff_s;
`endif
            if (idx_q == LAST_IDX) begin
              sent_d = 1'b1;
            end else begin
              idx_d = idx_q + logN'(1'b1);
            end
          end else begin
            ready_d = 1'b0;
          end
        end
      end

`ifdef POLY_CHECKSUM_EN
      S_CHK: begin
        if (sent_q) begin
          state_d = S_DONE;
          sent_d  = 1'b0;
        end else if (!bus.HOLD) begin
          dout_d  = sum_q;
          ready_d = 1'b1;
          sent_d  = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    write_d = (state_d == S_START);
`ifdef POLY_CHECKSUM_EN
    busy_d  = (state_d == S_START) || (state_d == S_SEND) || (state_d == S_CHK);
`else
    busy_d  = (state_d == S_START) || (state_d == S_SEND);
`endif
    done_d  = (state_d == S_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      sent_q   <= 1'b0;
      write_q  <= 1'b0;
      ready_q  <= 1'b0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef POLY_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      sent_q   <= sent_d;
      write_q  <= write_d;
      ready_q  <= ready_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef POLY_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign bus.WRITE          = write_q;
  assign bus.data_out_ready = ready_q;
  assign bus.data_out       = dout_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_poly_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_poly_stream_tx
// Directed vector table, hand-written corner sequences and randomized traffic
// for poly_stream_tx (N=8, b=5). Random and corner phases are compared with a
// queue-based frame model; the table carries its own literal expectations.
// -----------------------------------------------------------------------------
module tb_poly_stream_tx;
  localparam int N  = 8;
  localparam int B  = 5;
  localparam int NB = N * B;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  poly_stream_tx_if #(.b(B), .Nb(NB)) bus ();

  poly_stream_tx #(.p(17), .N(N), .logN(3), .b(B), .Nb(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          rst;
    logic          ld;
    logic          hold;
    logic [NB-1:0] poly;
    logic          w;
    logic          r;
    logic [B-1:0]  d;
    logic          bsy;
    logic          dn;
  } vec_t;

  vec_t vecs[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Frame model: mode 0 idle, 1 write cycle, 2 streaming, 3 done cycle.
  int           m_mode = 0;
  int           m_beats[$];
  logic         e_w, e_r, e_b, e_dn;
  logic [B-1:0] e_d;

  function automatic void model_edge(logic rst, logic ld, logic hold, logic [NB-1:0] poly);
    int sum;
    int c;
    if (rst) begin
      m_mode = 0;
      m_beats.delete();
      e_w = 1'b0; e_r = 1'b0; e_d = '0; e_b = 1'b0; e_dn = 1'b0;
      return;
    end
    e_w = 1'b0; e_r = 1'b0; e_dn = 1'b0;
    if (m_mode == 0 || m_mode == 3) begin
      if (ld) begin
        m_beats.delete();
        sum = 0;
        for (int i = 0; i < N; i++) begin
          c = int'((poly >> (B * i)) & 40'd31);
          m_beats.push_back(c);
          sum += c;
        end
`ifdef POLY_CHECKSUM_EN
        m_beats.push_back(sum % 32);
`endif
        m_mode = 1;
        e_w = 1'b1;
      end else begin
        m_mode = 0;
      end
    end else begin
      if (m_beats.size() == 0) begin
        m_mode = 3;
      end else begin
        m_mode = 2;
        if (!hold) begin
          e_d = 5'(m_beats.pop_front());
          e_r = 1'b1;
        end
      end
    end
    e_b  = (m_mode == 1 || m_mode == 2);
    e_dn = (m_mode == 3);
  endfunction

  function automatic void add(logic rst, logic ld, logic hold, logic [NB-1:0] poly,
                              logic w, logic r, logic [B-1:0] d, logic bsy, logic dn);
    vec_t v;
    v.rst = rst; v.ld = ld; v.hold = hold; v.poly = poly;
    v.w = w; v.r = r; v.d = d; v.bsy = bsy; v.dn = dn;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic rst, logic ld, logic hold, logic [NB-1:0] poly);
    reset       = rst;
    bus.LOAD    = ld;
    bus.HOLD    = hold;
    bus.poly_in = poly;
    @(posedge clk);
    #1;
    model_edge(rst, ld, hold, poly);
  endtask

  task automatic check(string name, logic w, logic r, logic [B-1:0] d, logic bsy, logic dn);
    vectors++;
    if ({bus.WRITE, bus.data_out_ready, bus.data_out, bus.busy, bus.done} !== {w, r, d, bsy, dn}) begin
      miscompares++;
      $display("FAIL %s: got W=%0b R=%0b D=%0d B=%0b Dn=%0b, need W=%0b R=%0b D=%0d B=%0b Dn=%0b",
               name, bus.WRITE, bus.data_out_ready, bus.data_out, bus.busy, bus.done,
               w, r, d, bsy, dn);
    end
  endtask

  task automatic step(string name, logic rst, logic ld, logic hold, logic [NB-1:0] poly);
    drive(rst, ld, hold, poly);
    check(name, e_w, e_r, e_d, e_b, e_dn);
  endtask

  logic [NB-1:0] pa, pf, pr;
  logic [63:0]   r64;
  logic [B-1:0]  last;

  initial begin
    for (int i = 0; i < N; i++) begin
      pa[i*B +: B] = 5'(i + 1);
      pf[i*B +: B] = 5'd31;
    end
`ifdef POLY_CHECKSUM_EN
    last = 5'd4;
`else
    last = 5'd8;
`endif

    // Frame of 1..8 with HOLD low.
    add(1'b1, 1'b0, 1'b0, pa, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, pa, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, pa, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 1; i <= N; i++)
      add(1'b0, 1'b0, 1'b0, pa, 1'b0, 1'b1, 5'(i), 1'b1, 1'b0);
`ifdef POLY_CHECKSUM_EN
    add(1'b0, 1'b0, 1'b0, pa, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
`endif
    add(1'b0, 1'b0, 1'b0, pa, 1'b0, 1'b0, last, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, pa, 1'b0, 1'b0, last, 1'b0, 1'b0);
    // HOLD for 3 edges after coefficient 2, with an all-31 LOAD that must be ignored.
    add(1'b0, 1'b1, 1'b0, pa, 1'b1, 1'b0, last, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, pa, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, pa, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b1, 1'b1, pf, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);
    for (int i = 3; i <= N; i++)
      add(1'b0, 1'b1, 1'b0, pf, 1'b0, 1'b1, 5'(i), 1'b1, 1'b0);
`ifdef POLY_CHECKSUM_EN
    add(1'b0, 1'b0, 1'b0, pa, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
`endif
    add(1'b0, 1'b0, 1'b0, pa, 1'b0, 1'b0, last, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, pa, 1'b0, 1'b0, last, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].hold, vecs[i].poly);
      check($sformatf("vec%0d", i), vecs[i].w, vecs[i].r, vecs[i].d, vecs[i].bsy, vecs[i].dn);
    end

    // Reset after 4 coefficients, then a fresh LOAD restarts at coeff[0].
    step("rst_load", 1'b0, 1'b1, 1'b0, pa);
    for (int i = 0; i < 4; i++) step("rst_pre", 1'b0, 1'b0, 1'b0, pa);
    step("rst_mid", 1'b1, 1'b1, 1'b0, pf);
    check("rst_zero", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("rst_reload", 1'b0, 1'b1, 1'b0, pf);
    for (int i = 0; i < 12; i++) step("rst_post", 1'b0, 1'b0, 1'b0, pa);

    // LOAD held high: back-to-back frames, reloaded in each DONE cycle.
    for (int i = 0; i < 36; i++) step("b2b", 1'b0, 1'b1, 1'b0, (i < 18) ? pa : pf);
    for (int i = 0; i < 14; i++) step("b2b_tail", 1'b0, 1'b0, 1'b0, pa);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r64 = {$urandom(), $urandom()};
      pr  = r64[NB-1:0];
      step("rand", ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), pr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/poly_stream_tx.md
POLY_STREAM_TX -- requirements
Module: poly_stream_tx

Interface
- REQ-001: Parameter p, default 17, coefficient modulus; carried for consistency with the polynomial storage blocks and unused by the datapath.
- REQ-002: Parameter N, default 8, coefficients per polynomial.
- REQ-003: Parameter logN, default 3, width of the coefficient index; N SHALL equal 2^logN.
- REQ-004: Parameter b, default 5, coefficient width in bits.
- REQ-005: Parameter Nb, default N*b, width of the packed polynomial.
- REQ-006: clk  input  1  single clock; all state SHALL update on the rising edge.
- REQ-007: reset  input  1  synchronous, active-high reset.
- REQ-008: LOAD  input  1  request to capture poly_in and start a frame.
- REQ-009: poly_in  input  Nb  packed polynomial; coefficient i occupies bits [i*b+b-1 : i*b].
- REQ-010: HOLD  input  1  stall request, sampled each edge while streaming.
- REQ-011: WRITE  output  1  one-cycle frame-start strobe toward the polynomial store.
- REQ-012: data_out_ready  output  1  data_out is valid this cycle.
- REQ-013: data_out  output  b  current coefficient.
- REQ-014: busy  output  1  a frame is in progress (START, SEND, CHK).
- REQ-015: done  output  1  one-cycle end-of-frame pulse.

Function
- REQ-016: The block SHALL implement the states IDLE, START, SEND, CHK and DONE; all outputs SHALL be registered.
- REQ-017: IDLE: while LOAD=1 at an edge, the block SHALL copy poly_in into an internal shadow register, clear the index to 0 and enter START.
- REQ-018: START: the block SHALL drive WRITE=1 for exactly one cycle and then enter SEND.
- REQ-019: SEND, edge with HOLD=0: the block SHALL drive data_out=coeff[index] and data_out_ready=1 in the following cycle, and increment the index.
- REQ-020: SEND, edge with HOLD=1: the block SHALL drive data_out_ready=0, keep data_out at its last value and leave the index unchanged.
- REQ-021: Coefficient 0 (the LSB slice of poly_in) SHALL be sent first and coefficient N-1 last.
- REQ-022: With HOLD held low, the block SHALL send N coefficients on N consecutive cycles.
- REQ-023: Latency: for LOAD sampled at edge k with HOLD low, WRITE SHALL be high in cycle k+1 and coeff[0] SHALL be valid in cycle k+2.
- REQ-024: After coeff[N-1] is emitted, the block SHALL enter CHK when POLY_CHECKSUM_EN is defined, otherwise DONE.
- REQ-025: The index SHALL NOT wrap; the transition out of SEND SHALL occur on index N-1.
- REQ-026: DONE: the block SHALL drive done=1 for one cycle with busy=0, then return to IDLE.
- REQ-027: A LOAD sampled in DONE SHALL be accepted exactly as in IDLE.
- REQ-028: LOAD asserted while busy=1 SHALL be ignored, and the shadow register SHALL NOT change.
- REQ-029: Changes on poly_in after capture SHALL NOT affect the frame in progress.
- REQ-030: Outside SEND and CHK beats, WRITE, data_out_ready and done SHALL be 0 except as stated above.

Reset
- REQ-031: On reset=1 at any edge, including mid-frame, the block SHALL enter IDLE.
- REQ-032: On reset=1, the shadow register, index and checksum SHALL clear to 0.
- REQ-033: On reset=1, WRITE, data_out_ready, data_out, busy and done SHALL all be 0 on the next cycle.
- REQ-034: Reset SHALL take priority over LOAD in the same cycle.

Configuration
- REQ-035: Macro POLY_CHECKSUM_EN defined: after the N coefficients, CHK SHALL emit one additional beat with data_out equal to the sum of all N coefficients modulo 2^b and data_out_ready=1; HOLD SHALL stall this beat identically to SEND.
- REQ-036: Macro POLY_CHECKSUM_EN undefined: the CHK state and the checksum accumulator SHALL be absent, and each frame SHALL be exactly N beats.

Verification (N=8, b=5)
- REQ-037: LOAD pulse with coefficients 1..8, HOLD=0 -> WRITE high one cycle, data_out 1,2,...,8 with data_out_ready high on 8 consecutive cycles, then done for one cycle.
- REQ-038: HOLD=1 for 3 edges after coefficient 2 -> data_out_ready low for 3 cycles with data_out=2, then 3..8 in order with no loss or duplication.
- REQ-039: LOAD with coefficients 31,...,31 asserted mid-frame -> ignored; the original 1..8 sequence completes unchanged.
- REQ-040: reset after 4 coefficients -> all outputs 0 next cycle; a new LOAD restarts at coeff[0] with WRITE re-issued.
- REQ-041: LOAD held high continuously -> back-to-back frames, each led by a WRITE cycle, the next LOAD accepted in the DONE cycle.
- REQ-042: POLY_CHECKSUM_EN defined, coefficients 1..8 -> ninth beat data_out=4 (36 mod 32), then done.
